// File: rtl/lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_ctrl_if
// Bundles the execute-stage request/response channel and the data-memory
// channel of the load/store unit.
//   req_*  : request from execute stage (valid/ready handshake)
//   resp_* : one-cycle completion pulse with error flag and load data
//   mem_*  : word-addressed data-memory port (read/write strobes, addr, data)
// Modports:
//   slave  : the load/store unit itself
//   master : the environment (execute stage + data memory)
// ---------------------------------------------------------------------------
interface lsu_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sext;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit in front of a word-addressed data memory. Takes one
// byte/half/word request at a time, checks alignment and range, selects the
// little-endian lane, performs sub-word stores as read-modify-write and
// returns sign- or zero-extended load data.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : lsu_ctrl_if.slave (request, response and memory channels)
// Timing (edges after the accept edge E0):
//   error      : resp on E0
//   load       : mem_re on E0, resp on E2
//   word store : mem_we on E0, resp on E1
//   sub store  : mem_re on E0, mem_we on E2, resp on E3
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_RD   = 3'd1,
        LD_FMT  = 3'd2,
        RMW_RD  = 3'd3,
        RMW_MRG = 3'd4,
        WR      = 3'd5
    } state_t;

    // Registered state and request fields
    state_t            r_state;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_mem_we;
    logic              r_mem_re;

    // Next-state values
    state_t            w_state_nx;
    logic [1:0]        w_size_nx;
    logic              w_sext_nx;
    logic [1:0]        w_lane_nx;
    logic [31:0]       w_wdata_nx;
    logic              w_resp_valid_nx;
    logic              w_resp_err_nx;
    logic [31:0]       w_resp_rdata_nx;
    logic [ADDR_W-1:0] w_mem_addr_nx;
    logic [31:0]       w_mem_wdata_nx;
    logic              w_mem_we_nx;
    logic              w_mem_re_nx;
    logic              w_req_bad;

    // Sign/zero-extended load value from the addressed lane of a memory word
    function automatic logic [31:0] fmt_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        sext
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = {{24{sext & b[7]}}, b};
            2'b01:   res = {{16{sext & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Memory word with the addressed byte/half lane replaced by store data
    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] res;
        res = word;
        case (size)
            2'b00:   res[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Illegal size, misalignment, or byte address beyond the memory
    function automatic logic req_is_bad(
        input logic [1:0]  size,
        input logic [31:0] addr
    );
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if (addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}}) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    // Inputs are only looked at in IDLE; everything else is sequenced from latched fields
    always_comb begin
        w_state_nx      = r_state;
        w_size_nx       = r_size;
        w_sext_nx       = r_sext;
        w_lane_nx       = r_lane;
        w_wdata_nx      = r_wdata;
        w_resp_valid_nx = 1'b0;
        w_resp_err_nx   = 1'b0;
        w_resp_rdata_nx = 32'h0000_0000;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_wdata_nx  = r_mem_wdata;
        w_mem_we_nx     = 1'b0;
        w_mem_re_nx     = 1'b0;
        w_req_bad       = req_is_bad(bus.req_size, bus.req_addr);

        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_size_nx  = bus.req_size;
                    w_sext_nx  = bus.req_sext;
                    w_lane_nx  = bus.req_addr[1:0];
                    w_wdata_nx = bus.req_wdata;
                    if (w_req_bad) begin
                        // Rejected without touching memory; stay ready
                        w_resp_valid_nx = 1'b1;
                        w_resp_err_nx   = 1'b1;
                    end else if (!bus.req_we) begin
                        w_mem_re_nx   = 1'b1;
                        w_mem_addr_nx = bus.req_addr[ADDR_W+1:2];
                        w_state_nx    = LD_RD;
                    end else if (bus.req_size == 2'b10) begin
                        w_mem_we_nx    = 1'b1;
                        w_mem_addr_nx  = bus.req_addr[ADDR_W+1:2];
                        w_mem_wdata_nx = bus.req_wdata;
                        w_state_nx     = WR;
                    end else begin
                        // Sub-word store: fetch the word first
                        w_mem_re_nx   = 1'b1;
                        w_mem_addr_nx = bus.req_addr[ADDR_W+1:2];
                        w_state_nx    = RMW_RD;
                    end
                end else begin
                    w_state_nx = IDLE;
                end
            end
            LD_RD: begin
                w_state_nx = LD_FMT;
            end
            LD_FMT: begin
                w_resp_valid_nx = 1'b1;
                w_resp_rdata_nx = fmt_load(bus.mem_rdata, r_size, r_lane, r_sext);
                w_state_nx      = IDLE;
            end
            RMW_RD: begin
                w_state_nx = RMW_MRG;
            end
            RMW_MRG: begin
                w_mem_wdata_nx = merge_store(bus.mem_rdata, r_wdata, r_size, r_lane);
                w_mem_we_nx    = 1'b1;
                w_state_nx     = WR;
            end
            WR: begin
                w_resp_valid_nx = 1'b1;
                w_state_nx      = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears a pending write strobe at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_size       <= 2'b00;
            r_sext       <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata      <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_wdata  <= 32'h0000_0000;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_size       <= w_size_nx;
            r_sext       <= w_sext_nx;
            r_lane       <= w_lane_nx;
            r_wdata      <= w_wdata_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_err   <= w_resp_err_nx;
            r_resp_rdata <= w_resp_rdata_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_wdata  <= w_mem_wdata_nx;
            r_mem_we     <= w_mem_we_nx;
            r_mem_re     <= w_mem_re_nx;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_re     = r_mem_re;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
// Drives lsu_ctrl through a word-addressed memory model. Expected results come
// from a fixed vector table and from a byte-array reference of memory.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;
    localparam int ADDR_W = 10;

    logic clk;
    logic rst_n;

    lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory seen by the DUT: read data the cycle after a sampled mem_re
    bit [31:0] tb_mem [1024];
    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= tb_mem[bus.mem_addr];
    end

    // Reference: flat byte array covering the whole byte space
    bit [7:0] ref_mem [4096];

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_op(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic err, output logic [31:0] rdata,
                          output int lat, output int nre, output int nwe);
        int nb;
        logic [31:0] v;
        nb  = 1 << size;
        err = (size == 2'b11) || ((addr % 32'(nb)) != 32'd0) || (addr >= 32'h1000);
        rdata = 32'h0;
        if (err) begin
            lat = 0; nre = 0; nwe = 0;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = 8'(wdata >> (8 * i));
            lat = (nb == 4) ? 1 : 3;
            nre = (nb == 4) ? 0 : 1;
            nwe = 1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + 32'(i)]) << (8 * i));
            if (sext && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            rdata = v;
            lat = 2; nre = 1; nwe = 0;
        end
    endtask

    // Issue one request and follow it to its response (bounded)
    task automatic run_op(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic err, output logic [31:0] rdata, output int lat,
                          output int nre, output int nwe, output logic excl,
                          output logic [31:0] saddr);
        logic done;
        chk("req_ready_before_op", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_sext  = sext;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = -1; nre = 0; nwe = 0; excl = 1'b0; done = 1'b0;
        err = 1'b0; rdata = 32'h0; saddr = 32'h0;
        for (int c = 0; c < 8 && !done; c++) begin
            if (bus.mem_re) begin nre++; saddr = 32'(bus.mem_addr); end
            if (bus.mem_we) begin nwe++; saddr = 32'(bus.mem_addr); end
            if (bus.mem_re && bus.mem_we) excl = 1'b1;
            if (bus.resp_valid) begin
                lat = c; err = bus.resp_err; rdata = bus.resp_rdata; done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nre;
        int          nwe;
    } vec_t;

    vec_t vt [17];

    logic        g_err, e_err, g_excl, r_we, r_sx;
    logic [31:0] g_rd, e_rd, g_sa, r_a, r_w;
    logic [1:0]  r_sz;
    int          g_lat, g_nre, g_nwe, e_lat, e_nre, e_nwe;
    logic        saw_we;

    // Global guard against a hung run
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            we    size   sext  addr    wdata          err   rdata          lat nre nwe
        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 1, 0, 1};
        vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0};
        vt[2]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h00000000, 1, 0, 1};
        vt[3]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 1'b0, 32'h00000000, 3, 1, 1};
        vt[4]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        1'b0, 32'hFFFFFF80, 2, 1, 0};
        vt[5]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        1'b0, 32'h00000080, 2, 1, 0};
        vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'h80223344, 2, 1, 0};
        vt[7]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h00000000, 1, 0, 1};
        vt[8]  = '{1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 1'b0, 32'h00000000, 3, 1, 1};
        vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        1'b0, 32'hABCD3344, 2, 1, 0};
        vt[10] = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        1'b0, 32'hFFFFABCD, 2, 1, 0};
        vt[11] = '{1'b0, 2'b01, 1'b0, 32'h20, 32'h0,        1'b0, 32'h00003344, 2, 1, 0};
        vt[12] = '{1'b0, 2'b00, 1'b1, 32'h21, 32'h0,        1'b0, 32'h00000033, 2, 1, 0};
        vt[13] = '{1'b0, 2'b10, 1'b0, 32'h02, 32'h0,        1'b1, 32'h00000000, 0, 0, 0};
        vt[14] = '{1'b1, 2'b01, 1'b0, 32'h01, 32'h1234,     1'b1, 32'h00000000, 0, 0, 0};
        vt[15] = '{1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        1'b1, 32'h00000000, 0, 0, 0};
        vt[16] = '{1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,      1'b1, 32'h00000000, 0, 0, 0};

        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_sext = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("reset_resp_err",   {31'd0, bus.resp_err},   32'd0);
        chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
        chk("reset_strobes",    {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
        chk("reset_mem_addr",   32'(bus.mem_addr), 32'd0);
        chk("reset_mem_wdata",  bus.mem_wdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            ref_op(vt[i].we, vt[i].size, vt[i].sext, vt[i].addr, vt[i].wdata,
                   e_err, e_rd, e_lat, e_nre, e_nwe);
            run_op(vt[i].we, vt[i].size, vt[i].sext, vt[i].addr, vt[i].wdata,
                   g_err, g_rd, g_lat, g_nre, g_nwe, g_excl, g_sa);
            chk($sformatf("vec%0d_err", i),   {31'd0, g_err}, {31'd0, vt[i].err});
            chk($sformatf("vec%0d_rdata", i), g_rd, vt[i].rdata);
            chk($sformatf("vec%0d_lat", i),   g_lat, vt[i].lat);
            chk($sformatf("vec%0d_nre", i),   g_nre, vt[i].nre);
            chk($sformatf("vec%0d_nwe", i),   g_nwe, vt[i].nwe);
            chk($sformatf("vec%0d_excl", i),  {31'd0, g_excl}, 32'd0);
            if (vt[i].nre + vt[i].nwe > 0)
                chk($sformatf("vec%0d_mem_addr", i), g_sa, {22'd0, vt[i].addr[11:2]});
        end

        // Back-to-back: load issued in the store's response cycle
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h40; bus.req_wdata = 32'hCAFEF00D;
        ref_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, e_err, e_rd, e_lat, e_nre, e_nwe);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_store_resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd2);
        chk("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h40;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("b2b_load_accepted", {30'd0, bus.mem_re, bus.resp_valid}, 32'd2);
        chk("b2b_load_addr", 32'(bus.mem_addr), 32'h10);
        @(posedge clk); @(posedge clk); #1;
        chk("b2b_load_resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd2);
        chk("b2b_load_data", bus.resp_rdata, 32'hCAFEF00D);

        // Reset while a byte store sits in its merge step
        ref_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, e_err, e_rd, e_lat, e_nre, e_nwe);
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, g_err, g_rd, g_lat, g_nre, g_nwe, g_excl, g_sa);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_addr = 32'h13; bus.req_wdata = 32'h80;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        saw_we = bus.mem_we;
        @(posedge clk); #1;
        saw_we = saw_we | bus.mem_we;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
        chk("rst_mid_resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
        chk("rst_mid_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
        repeat (2) begin @(posedge clk); #1; saw_we = saw_we | bus.mem_we; end
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_mid_no_write", {31'd0, saw_we}, 32'd0);
        chk("rst_mid_word_kept", tb_mem[4], 32'h11223344);
        ref_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e_err, e_rd, e_lat, e_nre, e_nwe);
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g_err, g_rd, g_lat, g_nre, g_nwe, g_excl, g_sa);
        chk("rst_mid_reload", g_rd, 32'h11223344);

        // Randomized traffic against the byte-array reference
        for (int i = 0; i < 200; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r_sx = 1'($urandom_range(0, 1));
            r_w  = $urandom;
            r_a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && r_sz != 2'b11) r_a = r_a & ~((32'd1 << r_sz) - 32'd1);
            if ($urandom_range(0, 15) == 0) r_a = r_a | (32'd1 << $urandom_range(12, 31));
            ref_op(r_we, r_sz, r_sx, r_a, r_w, e_err, e_rd, e_lat, e_nre, e_nwe);
            run_op(r_we, r_sz, r_sx, r_a, r_w, g_err, g_rd, g_lat, g_nre, g_nwe, g_excl, g_sa);
            chk($sformatf("rnd%0d_err", i),   {31'd0, g_err}, {31'd0, e_err});
            chk($sformatf("rnd%0d_rdata", i), g_rd, e_rd);
            chk($sformatf("rnd%0d_lat", i),   g_lat, e_lat);
            chk($sformatf("rnd%0d_strobes", i), g_nre * 4 + g_nwe, e_nre * 4 + e_nwe);
            chk($sformatf("rnd%0d_excl", i),  {31'd0, g_excl}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sitting directly upstream of the word-addressed data memory in the CPU datapath. Accepts one byte/half/word load or store request at a time from the execute stage. Performs alignment checks and little-endian lane selection. Implements sub-word stores as read-modify-write, and returns sign- or zero-extended load data.

Parameters:
ADDR_W, 10, word-address width driven to data memory (byte space = 2^(ADDR_W+2) bytes)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept a request (combinational: state==IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_sext  in  1  load sign-extend (1) / zero-extend (0); ignored for word and stores
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for byte/half
resp_valid  out  1  one-cycle completion pulse (registered)
resp_err  out  1  qualifies resp_valid: misaligned, illegal size or out-of-range
resp_rdata  out  32  formatted load data; 0 for stores and errors
mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2] (registered)
mem_wdata  out  32  full word to write (registered)
mem_we  out  1  write strobe (registered)
mem_re  out  1  read strobe (registered)
mem_rdata  in  32  memory read word, valid the cycle after the edge that sampled mem_re

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (req_ready=1 once out of reset); in-flight operation discarded; a pending mem_we drops immediately, so no partial write.
- Acceptance: edge where req_valid & req_ready; request fields latched. Inputs are ignored outside IDLE.
- Error check at acceptance:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:ADDR_W+2] nonzero
- Error response: resp_valid=1, resp_err=1 after the accept edge. No mem_re/mem_we ever asserted. State stays IDLE.
- States: IDLE, LD_RD, LD_FMT, RMW_RD, RMW_MRG, WR.
- Load (edges E0..E2):
  - E0 accept: mem_re=1, mem_addr set, -> LD_RD.
  - E1: mem_re=0, -> LD_FMT.
  - E2: resp_rdata formatted from mem_rdata, resp_valid=1, -> IDLE.
  - Latency: resp after 2 edges past accept.
- Word store:
  - E0: mem_we=1, mem_wdata=req_wdata, -> WR.
  - E1: mem_we=0, resp_valid=1, -> IDLE.
- Byte/half store:
  - E0: mem_re=1, -> RMW_RD.
  - E1: mem_re=0, -> RMW_MRG.
  - E2: mem_wdata = mem_rdata with lane replaced, mem_we=1, -> WR.
  - E3: ack as word store.
- Lane rules (little-endian):
  - Byte lane k=addr[1:0] occupies bits [8k+7:8k].
  - Half lane occupies bits [16h+15:16h], h=addr[1].
  - Store uses req_wdata[7:0] / [15:0].
- Load extension: byte/half replicated from MSB when req_sext=1, else zero-filled.
- resp_valid is high for exactly one cycle. State is IDLE during that cycle, so a new request may be accepted in the same cycle (back-to-back, no bubble).
- mem_addr / mem_wdata hold their last values when strobes are low.
- mem_re and mem_we are never both 1.

Test Plan:
- Store word 0xDEADBEEF @0x10, then lw @0x10 -> mem_we one cycle, addr 4; resp_rdata=0xDEADBEEF, resp_valid 2 edges after load accept.
- Word 0x11223344 @0x10; sb 0x80 @0x13 -> mem_re, then mem_we with wdata 0x80223344; lb sext @0x13 -> 0xFFFFFF80; lbu -> 0x00000080.
- Word 0x11223344 @0x20; sh 0xABCD @0x22 -> memory 0xABCD3344; lh sext @0x22 -> 0xFFFFABCD; lhu @0x20 -> 0x00003344.
- lw @0x02, sh @0x01, size=11, addr 0x1000 (ADDR_W=10) -> each: resp_valid=1, resp_err=1, resp_rdata=0 one edge after accept; mem_re=mem_we=0 throughout.
- Assert rst_n=0 during RMW_MRG of sb @0x13 -> mem_we never high, word unchanged, outputs 0, req_ready=1 after release.
- Issue a new lw in the same cycle as a store's resp_valid -> accepted that edge; both responses correct, no bubble.
